// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU types: next-PC select encoding and jump-region
//               boundary used by the fetch program counter.
// Revision    : 1.0 - initial release with pc_sel_t and J_HI
// ============================================================================
package cpu_types_pkg;

    // Next-PC source select; encodings 6 and 7 are unused and fall back to SEQ
    typedef enum logic [2:0] {
        SEQ = 3'd0,
        BR  = 3'd1,
        J   = 3'd2,
        JAL = 3'd3,
        JR  = 3'd4,
        RET = 3'd5
    } pc_sel_t;

    // Lowest PC bit kept from pc_plus_inc when forming a J/JAL target
    localparam int J_HI = 28;

endpackage
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_addr_stack
// Description : Circular return-address stack with a top pointer. A push
//               when full overwrites the oldest entry and sets a sticky
//               overflow flag. top reads as 0 while the stack is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module return_addr_stack
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_W-1:0]              push_data,
    output logic [ADDR_W-1:0]              top,
    output logic [$clog2(RAS_DEPTH):0]     count,
    output logic                           overflow
);

    localparam int c_PTR_W = $clog2(RAS_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [ADDR_W-1:0]  r_stack [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic [c_PTR_W-1:0] w_ptr_inc;
    logic [c_PTR_W-1:0] w_ptr_dec;

    // Pointer arithmetic wraps naturally because the depth is a power of 2
    always_comb begin
        w_ptr_inc = r_ptr + c_PTR_W'(1);
        w_ptr_dec = r_ptr - c_PTR_W'(1);
    end

    // Pointer, occupancy and sticky overflow; push wins if both are requested
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (push) begin
            r_ptr <= w_ptr_inc;
            if (r_count == c_CNT_W'(RAS_DEPTH)) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + c_CNT_W'(1);
            end
        end else if (pop && (r_count != '0)) begin
            r_ptr   <= w_ptr_dec;
            r_count <= r_count - c_CNT_W'(1);
        end
    end

    // Entry storage; contents need no reset since top is masked while empty
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            r_stack[w_ptr_inc] <= push_data;
        end
    end

    assign top      = (r_count == '0) ? '0 : r_stack[r_ptr];
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/pc_unit_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit_ras
// Description : Fetch program counter with next-PC select, priority
//               redirect/flush, fetch stall and JAL / RET prediction through
//               a return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit_ras
    import cpu_types_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] PC_INIT = '0,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       pc_en,
    input  logic                       stall,
    input  logic [2:0]                 pc_sel,
    input  logic                       br_taken,
    input  logic [15:0]                imm16,
    input  logic [25:0]                imm26,
    input  logic [ADDR_W-1:0]          rdat1,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [ADDR_W-1:0]          imemaddr,
    output logic [ADDR_W-1:0]          pc_plus_inc,
    output logic [ADDR_W-1:0]          ras_top,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_overflow
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_plus_inc;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_jump_tgt;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_ras_empty;

    assign w_pc_plus_inc = r_pc + ADDR_W'(INC);
    assign w_br_off      = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    assign w_jump_tgt    = {w_pc_plus_inc[ADDR_W-1:J_HI], imm26, 2'b00};
    assign w_accept      = pc_en & ~stall & ~redirect_valid;
    assign w_ras_empty   = (ras_count == '0);

    // Next-PC mux and RAS requests; stack ops only take effect on accept
    always_comb begin
        w_next_pc = w_pc_plus_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        case (pc_sel)
            BR:  if (br_taken) w_next_pc = w_pc_plus_inc + w_br_off;
            J:   w_next_pc = w_jump_tgt;
            JAL: begin
                w_next_pc = w_jump_tgt;
                w_push    = w_accept;
            end
            JR:  w_next_pc = rdat1;
            RET: begin
                if (w_ras_empty) begin
                    w_next_pc = rdat1;
                end else begin
                    w_next_pc = ras_top;
                    w_pop     = w_accept;
                end
            end
            default: w_next_pc = w_pc_plus_inc;
        endcase
    end

    // PC register: reset, then redirect, then accepted advance, else hold
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc <= PC_INIT;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_accept) begin
            r_pc <= w_next_pc;
        end
    end

    return_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .RST       (RST),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_plus_inc),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (ras_overflow)
    );

    assign imemaddr    = r_pc;
    assign pc_plus_inc = w_pc_plus_inc;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit_ras.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit_ras
// Description : Self-checking bench for pc_unit_ras. A behavioural reference
//               model predicts PC and return-stack state for each applied
//               vector; predictions are queued and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit_ras;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        pc_en = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  pc_sel = 3'd0;
    logic        br_taken = 1'b0;
    logic [15:0] imm16 = '0;
    logic [25:0] imm26 = '0;
    logic [31:0] rdat1 = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imemaddr;
    logic [31:0] pc_plus_inc;
    logic [31:0] ras_top;
    logic [2:0]  ras_count;
    logic        ras_overflow;

    pc_unit_ras #(
        .ADDR_W    (32),
        .PC_INIT   (32'h0),
        .INC       (4),
        .RAS_DEPTH (4)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .pc_en          (pc_en),
        .stall          (stall),
        .pc_sel         (pc_sel),
        .br_taken       (br_taken),
        .imm16          (imm16),
        .imm26          (imm26),
        .rdat1          (rdat1),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imemaddr       (imemaddr),
        .pc_plus_inc    (pc_plus_inc),
        .ras_top        (ras_top),
        .ras_count      (ras_count),
        .ras_overflow   (ras_overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ppi;
        logic [31:0] top;
        logic [31:0] cnt;
        logic [31:0] ovf;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ovf;
    int          n_vec  = 0;
    int          n_miss = 0;

    localparam logic [2:0] S_SEQ = 3'd0, S_BR = 3'd1, S_J = 3'd2,
                           S_JAL = 3'd3, S_JR = 3'd4, S_RET = 3'd5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one vector, predict the post-edge state, then compare after the edge
    task automatic apply(input string tag, input logic rst, input logic redir,
                         input logic [31:0] rpc, input logic stl, input logic en,
                         input logic [2:0] sel, input logic brt, input logic [15:0] i16,
                         input logic [25:0] i26, input logic [31:0] rd);
        exp_t        e;
        exp_t        o;
        logic [31:0] ppi;
        @(negedge CLK);
        RST = rst; redirect_valid = redir; redirect_pc = rpc; stall = stl;
        pc_en = en; pc_sel = sel; br_taken = brt; imm16 = i16; imm26 = i26; rdat1 = rd;
        ppi = m_pc + 32'd4;
        if (rst) begin
            m_pc = 32'h0;
            m_ras.delete();
            m_ovf = 1'b0;
        end else if (redir) begin
            m_pc = rpc;
        end else if (en && !stl) begin
            case (sel)
                S_BR:  m_pc = brt ? ppi + {{14{i16[15]}}, i16, 2'b00} : ppi;
                S_J:   m_pc = {ppi[31:28], i26, 2'b00};
                S_JAL: begin
                    m_pc = {ppi[31:28], i26, 2'b00};
                    m_ras.push_back(ppi);
                    if (m_ras.size() > 4) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                end
                S_JR:  m_pc = rd;
                S_RET: m_pc = (m_ras.size() > 0) ? m_ras.pop_back() : rd;
                default: m_pc = ppi;
            endcase
        end
        e.pc  = m_pc;
        e.ppi = m_pc + 32'd4;
        e.top = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
        e.cnt = m_ras.size();
        e.ovf = {31'd0, m_ovf};
        e.tag = tag;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        o = sb.pop_front();
        chk({o.tag, ".pc"},  imemaddr,              o.pc);
        chk({o.tag, ".ppi"}, pc_plus_inc,           o.ppi);
        chk({o.tag, ".top"}, ras_top,               o.top);
        chk({o.tag, ".cnt"}, {29'd0, ras_count},    o.cnt);
        chk({o.tag, ".ovf"}, {31'd0, ras_overflow}, o.ovf);
    endtask

    task automatic step(input string tag, input logic [2:0] sel, input logic brt,
                        input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rd);
        apply(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, sel, brt, i16, i26, rd);
    endtask

    task automatic redirect(input string tag, input logic [31:0] rpc);
        apply(tag, 1'b0, 1'b1, rpc, 1'b0, 1'b0, S_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
    endtask

    initial begin
        m_pc  = 32'h0;
        m_ovf = 1'b0;

        // Reset held two cycles with pc_en high
        apply("rst0", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, S_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
        apply("rst1", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, S_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);

        // Sequential advance, then stall and disabled fetch hold the PC
        for (int i = 0; i < 3; i++) step("seq", S_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
        apply("stall0", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, S_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
        apply("stall1", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, S_JAL, 1'b0, 16'h0, 26'h40, 32'h0);
        apply("noen",   1'b0, 1'b0, 32'h0, 1'b0, 1'b0, S_JAL, 1'b0, 16'h0, 26'h40, 32'h0);

        // Branches from 0x100
        redirect("rd100a", 32'h100);
        step("br_neg", S_BR, 1'b1, 16'hFFFF, 26'h0, 32'h0);
        step("br_pos", S_BR, 1'b1, 16'h0003, 26'h0, 32'h0);
        redirect("rd100b", 32'h100);
        step("br_nt",  S_BR, 1'b0, 16'h0003, 26'h0, 32'h0);

        // Call / return, then RET on an empty stack uses rdat1
        redirect("rd100c", 32'h100);
        step("jal",     S_JAL, 1'b0, 16'h0, 26'h40, 32'h0);
        step("ret",     S_RET, 1'b0, 16'h0, 26'h0,  32'hBAD0);
        step("ret_emp", S_RET, 1'b0, 16'h0, 26'h0,  32'h200);
        step("jr",      S_JR,  1'b0, 16'h0, 26'h0,  32'h3C0);

        // Overflow: five calls into a four-entry stack, then unwind
        for (int i = 0; i < 5; i++)
            step("jal_ovf", S_JAL, 1'b0, 16'h0, 26'h100 + 26'(i * 16), 32'h0);
        for (int i = 0; i < 4; i++)
            step("ret_lifo", S_RET, 1'b0, 16'h0, 26'h0, 32'hDEAD0);
        step("ret_lost", S_RET, 1'b0, 16'h0, 26'h0, 32'h5550);

        // Upper-region jump, address wrap-around and an unused select code
        redirect("rdhi", 32'hF000_0000);
        step("j_hi",  S_J, 1'b0, 16'h0, 26'h1, 32'h0);
        redirect("rdwrap", 32'hFFFF_FFFC);
        step("wrap",  S_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
        step("sel7",  3'd7,  1'b1, 16'h0010, 26'h3, 32'h700);

        // Redirect beats stall and suppresses push/pop; reset beats redirect
        step("jal_pri", S_JAL, 1'b0, 16'h0, 26'h20, 32'h0);
        apply("redir_jal", 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, S_JAL, 1'b0, 16'h0, 26'h40, 32'h0);
        apply("redir_ret", 1'b0, 1'b1, 32'h90, 1'b0, 1'b1, S_RET, 1'b0, 16'h0, 26'h0, 32'h0);
        apply("rst_win",   1'b1, 1'b1, 32'h80, 1'b0, 1'b1, S_JAL, 1'b0, 16'h0, 26'h40, 32'h0);
        step("post_rst", S_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);

        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL sb_drain: got %0d expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
